read_master_burst_ch: RTL and testbench

- Parametrised successor to the single-width Avalon-MM burst read master in the face-detection datapath.
- Streams a contiguous byte region from memory into an internal FIFO.
- Core logic pops words from the FIFO through the existing read-request / wait-request handshake.
- New capabilities: configurable data width, burst size and FIFO depth; exact-length transfers with a shortened final burst; credit-based flow control that never overflows the FIFO; explicit busy and done status.

---
 rtl/rmb_pkg.sv | 30 +++
 rtl/sc_fifo_usedw.sv | 69 ++++++
 rtl/read_master_burst_ch.sv | 166 ++++++++++++++++
 tb/tb_read_master_burst_ch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmb_pkg.sv
// Shared definitions for the parametrised Avalon-MM burst read master.
//   state_t         : top-level transfer FSM states
//   clog2           : ceiling log2, usable in parameter and port-width expressions
//   bytes_per_word  : bytes carried by one Avalon data beat
//   burst_bytes     : bytes covered by one full-size burst
package rmb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    DRAIN
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int burst_bytes(input int data_width, input int burst_length);
    return burst_length * (data_width / 8);
  endfunction

endpackage

// File: rtl/sc_fifo_usedw.sv
// Single-clock FIFO with fill-level output and a registered read port.
//   clk      : clock
//   clr      : synchronous active-high flush of pointers, level and read flag
//   wr_en    : write wr_data this cycle
//   wr_data  : write data
//   rd_req   : pop request; ignored while empty unless a write arrives in the same cycle
//   rd_data  : popped word, valid the cycle after the pop
//   rd_valid : registered pop flag qualifying rd_data
//   empty    : no word available
//   usedw    : number of stored words, 0..FIFO_DEPTH
module sc_fifo_usedw
  import rmb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_req,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic [clog2(FIFO_DEPTH):0] usedw
);

  localparam int PTR_W = clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign empty = (usedw == '0);
  assign full  = usedw[PTR_W];

  // A pop on an empty FIFO is honoured only when a write lands in the same
  // cycle; that word is forwarded straight to rd_data. A write into a full
  // FIFO is honoured only when a pop frees a slot in the same cycle.
  assign pop  = rd_req && (!empty || wr_en);
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
    if (pop)  rd_data <= empty ? wr_data : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   usedw <= usedw + (PTR_W + 1)'(1);
        2'b01:   usedw <= usedw - (PTR_W + 1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

// File: rtl/read_master_burst_ch.sv
// Avalon-MM burst read master: streams a contiguous byte region into an
// internal FIFO that the core drains through a read-request/wait-request pair.
//   iClk, iReset          : clock, synchronous active-high reset
//   iStart                : start pulse, honoured only while oBusy=0
//   iStart_read_address   : word-aligned byte start address
//   iLength               : byte count, sub-word bits ignored
//   oBusy, oDone          : transfer in progress / one-cycle completion pulse
//   iRead_data_valid, iWait_request, iRead_data : Avalon readdatavalid, waitrequest, readdata
//   oRead, oRead_address, oBurst_length         : Avalon read, address, burstcount
//   iRM_read_request      : FIFO pop request from the core
//   oRM_wait_request      : FIFO empty
//   oOutput_ready         : oRM_read_data valid this cycle
//   oRM_read_data         : FIFO output word
module read_master_burst_ch
  import rmb_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int BURST_LENGTH     = 64,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int FIFO_DEPTH       = 256,
  parameter int LENGTH_WIDTH     = 32
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [ADDR_WIDTH-1:0]       iStart_read_address,
  input  logic [LENGTH_WIDTH-1:0]     iLength,
  output logic                        oBusy,
  output logic                        oDone,
  input  logic                        iRead_data_valid,
  input  logic                        iWait_request,
  input  logic [DATA_WIDTH-1:0]       iRead_data,
  output logic                        oRead,
  output logic [ADDR_WIDTH-1:0]       oRead_address,
  output logic [BURSTCOUNT_WIDTH-1:0] oBurst_length,
  input  logic                        iRM_read_request,
  output logic                        oRM_wait_request,
  output logic                        oOutput_ready,
  output logic [DATA_WIDTH-1:0]       oRM_read_data
);

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int WORD_SHIFT     = clog2(BYTES_PER_WORD);
  localparam int USED_W         = clog2(FIFO_DEPTH) + 1;
  // usedw, outstanding and a burst are each <= FIFO_DEPTH, so their sum fits
  // in one extra bit.
  localparam int CREDIT_W       = USED_W + 1;

  state_t                        state;
  state_t                        state_nxt;
  logic [ADDR_WIDTH-1:0]         address;
  logic [LENGTH_WIDTH-1:0]       words_left;
  logic [LENGTH_WIDTH-1:0]       start_words;
  logic [LENGTH_WIDTH-1:0]       words_left_after;
  logic [BURSTCOUNT_WIDTH-1:0]   burst_size;
  logic [USED_W-1:0]             outstanding;
  logic [USED_W-1:0]             outstanding_nxt;
  logic [USED_W-1:0]             fifo_used;
  logic                          fifo_empty;
  logic                          credit_ok;
  logic                          accept;

  assign start_words      = iLength >> WORD_SHIFT;
  assign burst_size       = (words_left >= LENGTH_WIDTH'(BURST_LENGTH))
                            ? BURSTCOUNT_WIDTH'(BURST_LENGTH)
                            : words_left[BURSTCOUNT_WIDTH-1:0];
  assign words_left_after = words_left - LENGTH_WIDTH'(oBurst_length);
  assign accept           = (state == HOLD) && oRead && !iWait_request;

  // Space is reserved for every word already requested but not yet returned,
  // so a burst is only issued when the FIFO can absorb all of it.
  assign credit_ok = ({1'b0, fifo_used} + {1'b0, outstanding} + CREDIT_W'(burst_size))
                     <= CREDIT_W'(FIFO_DEPTH);

  // An acceptance and a returning beat in the same cycle are both applied.
  always_comb begin
    outstanding_nxt = outstanding;
    if (accept)           outstanding_nxt = outstanding_nxt + USED_W'(oBurst_length);
    if (iRead_data_valid) outstanding_nxt = outstanding_nxt - USED_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (iStart && (start_words != '0)) state_nxt = ISSUE;
      ISSUE:   if (credit_ok && (words_left != '0)) state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = (words_left_after != '0) ? ISSUE : DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state         <= IDLE;
      oRead         <= 1'b0;
      oRead_address <= '0;
      oBurst_length <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      address       <= '0;
      words_left    <= '0;
      outstanding   <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      oDone       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            if (start_words == '0) begin
              oDone <= 1'b1;
            end else begin
              address    <= iStart_read_address;
              words_left <= start_words;
              oBusy      <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (state_nxt == HOLD) begin
            oRead         <= 1'b1;
            oRead_address <= address;
            oBurst_length <= burst_size;
          end
        end
        HOLD: begin
          // Dropping oRead on acceptance guarantees an idle cycle in ISSUE
          // before the next burst.
          if (accept) begin
            oRead      <= 1'b0;
            words_left <= words_left_after;
            address    <= address + (ADDR_WIDTH'(oBurst_length) << WORD_SHIFT);
          end
        end
        DRAIN: begin
          // Uses the post-update count so oDone follows the final beat by one cycle.
          if (state_nxt == IDLE) begin
            oDone <= 1'b1;
            oBusy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sc_fifo_usedw #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (iClk),
    .clr      (iReset),
    .wr_en    (iRead_data_valid),
    .wr_data  (iRead_data),
    .rd_req   (iRM_read_request),
    .rd_data  (oRM_read_data),
    .rd_valid (oOutput_ready),
    .empty    (fifo_empty),
    .usedw    (fifo_used)
  );

  assign oRM_wait_request = fifo_empty;

endmodule

// File: tb/tb_read_master_burst_ch.sv
module tb_read_master_burst_ch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Primary instance: 32-bit data, 128-word FIFO
  logic        rst, start, busy, done, rdv, wreq, rd, rm_req, rm_wait, out_ready;
  logic [31:0] start_addr, length, rdata, raddr, rm_data;
  logic [6:0]  blen;

  read_master_burst_ch #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LENGTH(64),
    .BURSTCOUNT_WIDTH(7), .FIFO_DEPTH(128), .LENGTH_WIDTH(32)
  ) u_dut (
    .iClk(clk), .iReset(rst), .iStart(start), .iStart_read_address(start_addr),
    .iLength(length), .oBusy(busy), .oDone(done), .iRead_data_valid(rdv),
    .iWait_request(wreq), .iRead_data(rdata), .oRead(rd), .oRead_address(raddr),
    .oBurst_length(blen), .iRM_read_request(rm_req), .oRM_wait_request(rm_wait),
    .oOutput_ready(out_ready), .oRM_read_data(rm_data)
  );

  // Secondary instance: 128-bit data
  logic         start2, busy2, done2, rdv2, wreq2, rd2, rm_req2, rm_wait2, ready2;
  logic [31:0]  addr2, len2, raddr2;
  logic [6:0]   blen2;
  logic [127:0] rdata2, rm_data2;

  read_master_burst_ch #(
    .DATA_WIDTH(128), .ADDR_WIDTH(32), .BURST_LENGTH(64),
    .BURSTCOUNT_WIDTH(7), .FIFO_DEPTH(256), .LENGTH_WIDTH(32)
  ) u_dut128 (
    .iClk(clk), .iReset(rst), .iStart(start2), .iStart_read_address(addr2),
    .iLength(len2), .oBusy(busy2), .oDone(done2), .iRead_data_valid(rdv2),
    .iWait_request(wreq2), .iRead_data(rdata2), .oRead(rd2), .oRead_address(raddr2),
    .oBurst_length(blen2), .iRM_read_request(rm_req2), .oRM_wait_request(rm_wait2),
    .oOutput_ready(ready2), .oRM_read_data(rm_data2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory responder state for the primary instance
  logic [31:0] beat_q[$];
  logic [31:0] burst_addr_log[$];
  int          burst_len_log[$];
  int          acc_count = 0;
  int          beats_ret = 0;
  int          last_beat_cycle = 0;
  int          stall_left = 0;
  int          done_cnt = 0;

  // Acceptance is judged mid-cycle; read data (= word byte address) and
  // waitrequest are driven just after the rising edge.
  initial begin
    rdv = 1'b0; rdata = '0; wreq = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_q.delete();
        stall_left = 0;
      end else begin
        if (done) done_cnt++;
        if (rd && !wreq) begin
          acc_count++;
          burst_addr_log.push_back(raddr);
          burst_len_log.push_back(int'(blen));
          for (int i = 0; i < int'(blen); i++) beat_q.push_back(raddr + 32'(i * 4));
        end
      end
      @(posedge clk); #1;
      if (beat_q.size() > 0) begin
        rdv = 1'b1;
        rdata = beat_q.pop_front();
        beats_ret++;
        last_beat_cycle = cycle;
      end else begin
        rdv = 1'b0;
      end
      if (rd && stall_left > 0) begin
        wreq = 1'b1;
        stall_left--;
      end else begin
        wreq = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] len);
    start_addr = a; length = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int bound);
    int k;
    k = 0;
    while (acc_count < target && k < bound) begin tick(); k++; end
    chk("accept_wait", 128'(acc_count >= target), 128'(1));
  endtask

  task automatic drain(input logic [31:0] first, input int n, input int bound);
    int got, k;
    logic [31:0] exp;
    got = 0; k = 0; exp = first;
    rm_req = 1'b1;
    while (got < n && k < bound) begin
      tick(); k++;
      if (out_ready) begin
        chk("pop_data", 128'(rm_data), 128'(exp));
        exp += 32'd4;
        got++;
      end
    end
    rm_req = 1'b0;
    chk("pop_count", 128'(got), 128'(n));
  endtask

  initial begin
    int base, dbase, bbase, k, hold, stable;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; rm_req = 1'b0;
    start2 = 1'b0; addr2 = 32'h500; len2 = '0; rdv2 = 1'b0; wreq2 = 1'b0;
    rdata2 = '0; rm_req2 = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_read", 128'(rd), 128'(0));
    chk("rst_addr", 128'(raddr), 128'(0));
    chk("rst_blen", 128'(blen), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ready", 128'(out_ready), 128'(0));
    chk("rst_empty", 128'(rm_wait), 128'(1));
    rst = 1'b0;
    tick();

    // Zero length: done next cycle, never busy, no read
    base = acc_count;
    pulse_start(32'h40, 32'd0);
    chk("len0_done", 128'(done), 128'(1));
    chk("len0_busy", 128'(busy), 128'(0));
    chk("len0_read", 128'(rd), 128'(0));
    tick();
    chk("len0_done_pulse", 128'(done), 128'(0));
    repeat (3) tick();
    chk("len0_no_burst", 128'(acc_count - base), 128'(0));

    // Single full burst, 256 bytes at 0x1000
    burst_addr_log.delete(); burst_len_log.delete();
    bbase = beats_ret;
    pulse_start(32'h1000, 32'd256);
    chk("b1_busy", 128'(busy), 128'(1));
    k = 0;
    while (!done && k < 300) begin tick(); k++; end
    chk("b1_done_seen", 128'(done), 128'(1));
    chk("b1_done_latency", 128'(cycle - last_beat_cycle), 128'(1));
    chk("b1_beats", 128'(beats_ret - bbase), 128'(64));
    chk("b1_nbursts", 128'(burst_addr_log.size()), 128'(1));
    chk("b1_addr", 128'(burst_addr_log[0]), 128'(32'h1000));
    chk("b1_len", 128'(burst_len_log[0]), 128'(64));
    tick();
    chk("b1_busy_clear", 128'(busy), 128'(0));
    chk("b1_fifo_nonempty", 128'(rm_wait), 128'(0));
    drain(32'h1000, 64, 200);
    chk("b1_fifo_empty", 128'(rm_wait), 128'(1));

    // 1000 bytes = 250 words with a live consumer; short final burst
    burst_addr_log.delete(); burst_len_log.delete();
    dbase = done_cnt;
    pulse_start(32'h0, 32'd1000);
    drain(32'h0, 250, 3000);
    repeat (3) tick();
    chk("b4_done_once", 128'(done_cnt - dbase), 128'(1));
    chk("b4_busy", 128'(busy), 128'(0));
    chk("b4_nbursts", 128'(burst_addr_log.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("b4_addr", 128'(burst_addr_log[i]), 128'(32'h100 * i));
      chk("b4_len", 128'(burst_len_log[i]), 128'((i == 3) ? 58 : 64));
    end

    // Stalled consumer, 1024 bytes, waitrequest on second burst, ignored restart
    burst_addr_log.delete(); burst_len_log.delete();
    base = acc_count; dbase = done_cnt;
    pulse_start(32'h2000, 32'd1024);
    wait_acc(base + 1, 50);
    stall_left = 5;
    k = 0;
    while (!rd && k < 20) begin tick(); k++; end
    hold = 0; stable = 1;
    while (rd && hold < 20) begin
      hold++;
      if (raddr !== 32'h2100 || blen !== 7'd64) stable = 0;
      tick();
    end
    chk("hold_cycles", 128'(hold), 128'(6));
    chk("hold_stable", 128'(stable), 128'(1));
    chk("hold_accepts", 128'(acc_count - base), 128'(2));
    pulse_start(32'h9000, 32'd64);
    repeat (150) tick();
    chk("credit_bursts", 128'(acc_count - base), 128'(2));
    chk("credit_read_low", 128'(rd), 128'(0));
    chk("credit_busy", 128'(busy), 128'(1));
    drain(32'h2000, 64, 200);
    wait_acc(base + 3, 50);
    chk("credit_third_addr", 128'(burst_addr_log[2]), 128'(32'h2200));
    drain(32'h2100, 192, 3000);
    repeat (5) tick();
    chk("credit_done_once", 128'(done_cnt - dbase), 128'(1));
    chk("credit_total_bursts", 128'(acc_count - base), 128'(4));
    chk("credit_last_addr", 128'(burst_addr_log[burst_addr_log.size() - 1]), 128'(32'h2300));
    chk("credit_idle", 128'(busy), 128'(0));
    chk("credit_fifo_empty", 128'(rm_wait), 128'(1));

    // Reset mid-transfer, then a clean transfer
    base = acc_count;
    pulse_start(32'h3000, 32'd512);
    wait_acc(base + 1, 50);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_read", 128'(rd), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_empty", 128'(rm_wait), 128'(1));
    repeat (3) tick();
    chk("mrst_still_idle", 128'(rd), 128'(0));
    burst_addr_log.delete(); burst_len_log.delete();
    dbase = done_cnt;
    pulse_start(32'h4000, 32'd64);
    drain(32'h4000, 16, 300);
    repeat (3) tick();
    chk("post_rst_done", 128'(done_cnt - dbase), 128'(1));
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_len", 128'(burst_len_log[0]), 128'(16));

    // 128-bit instance: 48 bytes = one burst of 3 words
    len2 = 32'd48; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while (!rd2 && k < 20) begin tick(); k++; end
    chk("w128_read", 128'(rd2), 128'(1));
    chk("w128_addr", 128'(raddr2), 128'(32'h500));
    chk("w128_blen", 128'(blen2), 128'(3));
    tick();
    chk("w128_read_drop", 128'(rd2), 128'(0));
    for (int i = 0; i < 3; i++) begin
      rdv2 = 1'b1;
      rdata2 = {96'hA5A5_0000_0000_0000_0000_0000, 32'(i)};
      tick();
    end
    rdv2 = 1'b0;
    chk("w128_done", 128'(done2), 128'(1));
    chk("w128_busy", 128'(busy2), 128'(0));
    rm_req2 = 1'b1;
    tick();
    rm_req2 = 1'b0;
    chk("w128_ready", 128'(ready2), 128'(1));
    chk("w128_data", rm_data2, {96'hA5A5_0000_0000_0000_0000_0000, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
